pipelined_decoder: RTL and testbench

//   Parametrised, pipelined binary-to-one-hot decoder with valid/ready flow control.

---
 rtl/decoder_pkg.sv | 24 ++
 rtl/pipe_slot.sv | 35 +++
 rtl/pipelined_decoder.sv | 83 ++++++++
 tb/tb_pipelined_decoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and the one-hot decode helper for the pipelined register-file write decoder.
// Sized for the widest legal configuration; instances slice down to their own widths.
package decoder_pkg;

  localparam int unsigned MAX_ADDR_W = 6;
  localparam int unsigned MAX_STAGES = 4;
  localparam int unsigned MAX_OUT_W  = 2 ** MAX_ADDR_W;

  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] addr;
  } slot_t;

  function automatic logic [MAX_OUT_W-1:0] onehot_f(input logic [MAX_ADDR_W-1:0] addr,
                                                    input logic                  valid);
    logic [MAX_OUT_W-1:0] vec;
    vec = '0;
    if (valid) begin
      vec[addr] = 1'b1;
    end
    return vec;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid bit plus address, loaded from upstream whenever the slot advances.
module pipe_slot
  import decoder_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  advance_i,
  input  slot_t up_i,
  output slot_t slot_o
);

  slot_t slot_d, slot_q;

  // The address is only captured with a real request so an idle slot keeps its last value.
  always_comb begin
    slot_d = slot_q;
    if (advance_i) begin
      slot_d.valid = up_i.valid;
      if (up_i.valid) begin
        slot_d.addr = up_i.addr;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/pipelined_decoder.sv
// Pipelined binary-to-one-hot write-enable decoder with valid/ready flow control.
// Define ZERO_REG_EN to suppress the enable for the top address (hard-wired zero register).
module pipelined_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [2**ADDR_W-1:0] out_onehot
);

  localparam int unsigned OutW = 2 ** ADDR_W;

  if (ADDR_W == 0 || ADDR_W > MAX_ADDR_W) begin : g_bad_addr_w
    $error("pipelined_decoder: ADDR_W must be in 1..%0d", MAX_ADDR_W);
  end
  if (STAGES == 0 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("pipelined_decoder: STAGES must be in 1..%0d", MAX_STAGES);
  end

  slot_t             up   [STAGES];
  slot_t             slot [STAGES];
  logic [STAGES-1:0] advance;
  slot_t             last;
  logic              decode_en;

  // A slot advances if it or any slot downstream of it is empty, or the consumer takes the
  // output; this is what lets bubbles collapse under a stall.
  always_comb begin
    logic carry;
    carry   = out_ready;
    advance = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      carry      = carry | ~slot[i].valid;
      advance[i] = carry;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign up[i] = {in_valid, MAX_ADDR_W'(in_addr)};
    end else begin : g_body
      assign up[i] = slot[i-1];
    end

    pipe_slot u_slot (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .advance_i (advance[i]),
      .up_i      (up[i]),
      .slot_o    (slot[i])
    );
  end

  assign last      = slot[STAGES-1];
  assign in_ready  = advance[0];
  assign out_valid = last.valid;
  assign out_addr  = last.addr[ADDR_W-1:0];

`ifdef ZERO_REG_EN
  assign decode_en = last.valid && (last.addr != MAX_ADDR_W'(OutW - 1));
`else
  assign decode_en = last.valid;
`endif

  // Decoded straight from the registered last slot, so no input path reaches the enables.
  assign out_onehot = OutW'(onehot_f(last.addr, decode_en));

  assert property (@(posedge clk) disable iff (!reset_n)
    out_valid && !out_ready |=> out_valid && $stable(out_addr) && $stable(out_onehot));

  assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(out_onehot) && (out_valid || out_onehot == '0));

endmodule

// File: tb/tb_pipelined_decoder.sv
// Self-checking bench for pipelined_decoder: directed scenarios plus randomized traffic
// checked against a queue-based transaction model.
module tb_pipelined_decoder;

  localparam int unsigned AW = 5;
  localparam int unsigned ST = 2;
  localparam int unsigned OW = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [OW-1:0] out_onehot;

  always #5 clk = ~clk;

  pipelined_decoder #(
    .ADDR_W (AW),
    .STAGES (ST)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_onehot (out_onehot)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            t;
  } req_t;

  req_t q[$];
  int   cyc          = 0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic          o_in_ready, o_out_valid;
  logic [AW-1:0] o_addr;
  logic [OW-1:0] o_onehot;
  logic          e_in_ready, e_out_valid;
  logic [AW-1:0] e_addr;
  logic [OW-1:0] e_onehot;

  function automatic logic [OW-1:0] ref_onehot(input logic [AW-1:0] a);
`ifdef ZERO_REG_EN
    if (int'(a) == int'(OW) - 1) return '0;
`endif
    return OW'(1) << a;
  endfunction

  // One clock cycle: drive at the falling edge, sample and predict, then apply the edge to
  // the model. Requests are in flight from acceptance until emitted; the oldest one is
  // visible ST cycles after acceptance, and the block is ready if not full or if draining.
  task automatic step(input logic rn, input logic iv, input logic [AW-1:0] ia,
                      input logic ordy);
    @(negedge clk);
    reset_n   = rn;
    in_valid  = iv;
    in_addr   = ia;
    out_ready = ordy;
    #1;
    o_in_ready  = in_ready;
    o_out_valid = out_valid;
    o_addr      = out_addr;
    o_onehot    = out_onehot;
    e_in_ready  = (q.size() < int'(ST)) || ordy;
    e_out_valid = (q.size() > 0) && (cyc >= q[0].t + int'(ST));
    e_addr      = e_out_valid ? q[0].addr : '0;
    e_onehot    = e_out_valid ? ref_onehot(q[0].addr) : '0;
    @(posedge clk);
    if (!rn) begin
      q.delete();
    end else begin
      if (o_out_valid && ordy && q.size() > 0) q.delete(0);
      if (iv && o_in_ready) q.push_back('{addr: ia, t: cyc});
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < int'(ST) + 3; i++) step(1'b1, 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, AW'($urandom_range(0, OW - 1)), 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    tests_run++;
    if (o_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b want 0", o_out_valid);
    end
    tests_run++;
    if (o_onehot !== '0) begin
      tests_failed++;
      $display("FAIL reset_onehot: got %h want 0", o_onehot);
    end
    tests_run++;
    if (o_addr !== '0) begin
      tests_failed++;
      $display("FAIL reset_out_addr: got %0d want 0", o_addr);
    end
    tests_run++;
    if (o_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b want 1", o_in_ready);
    end
  endtask

  task automatic test_latency();
    step(1'b1, 1'b1, AW'(5), 1'b1);
    tests_run++;
    if (o_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_c0_valid: got %b want 0", o_out_valid);
    end
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      tests_run++;
      if (o_out_valid !== (k == int'(ST))) begin
        tests_failed++;
        $display("FAIL latency_c%0d_valid: got %b want %b", k, o_out_valid, k == int'(ST));
      end
      tests_run++;
      if (k == int'(ST) && o_onehot !== 32'h0000_0020) begin
        tests_failed++;
        $display("FAIL latency_onehot: got %h want 00000020", o_onehot);
      end else if (k != int'(ST) && o_onehot !== '0) begin
        tests_failed++;
        $display("FAIL latency_c%0d_onehot: got %h want 0", k, o_onehot);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] got[$];
    logic          sent3;
    step(1'b1, 1'b1, AW'(1), 1'b0);
    tests_run++;
    if (o_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_accept1: in_ready got %b want 1", o_in_ready);
    end
    step(1'b1, 1'b1, AW'(2), 1'b0);
    tests_run++;
    if (o_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_accept2: in_ready got %b want 1", o_in_ready);
    end
    step(1'b1, 1'b1, AW'(3), 1'b0);
    tests_run++;
    if (o_in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full: in_ready got %b want 0", o_in_ready);
    end
    sent3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, !sent3, AW'(3), 1'b1);
      if (o_out_valid) got.push_back(o_addr);
      if (!sent3 && o_in_ready) sent3 = 1'b1;
    end
    tests_run++;
    if (sent3 !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_third_accept: accepted %b want 1", sent3);
    end
    tests_run++;
    if (got.size() != 3) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d outputs want 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== AW'(i + 1)) begin
        tests_failed++;
        $display("FAIL bp_order[%0d]: got %0d want %0d", i, got[i], i + 1);
      end
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b1, AW'($urandom_range(0, OW - 1)), 1'b0);
    step(1'b1, 1'b1, AW'($urandom_range(0, OW - 1)), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, AW'($urandom_range(0, OW - 1)), 1'b1);
      tests_run++;
      if (o_in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL sim_ready[%0d]: got %b want 1", i, o_in_ready);
      end
      tests_run++;
      if (o_out_valid !== 1'b1 || o_addr !== e_addr || o_onehot !== e_onehot) begin
        tests_failed++;
        $display("FAIL sim_out[%0d]: got v=%b a=%0d oh=%h want v=1 a=%0d oh=%h",
                 i, o_out_valid, o_addr, o_onehot, e_addr, e_onehot);
      end
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    step(1'b1, 1'b1, AW'($urandom_range(0, OW - 1)), 1'b0);
    step(1'b1, 1'b1, AW'($urandom_range(0, OW - 1)), 1'b0);
    step(1'b0, 1'b1, AW'($urandom_range(0, OW - 1)), 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      tests_run++;
      if (o_out_valid !== 1'b0 || o_onehot !== '0) begin
        tests_failed++;
        $display("FAIL midflight_discard[%0d]: got v=%b oh=%h want v=0 oh=0",
                 i, o_out_valid, o_onehot);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic          found;
    logic [OW-1:0] want_top;
`ifdef ZERO_REG_EN
    want_top = '0;
`else
    want_top = 32'h8000_0000;
`endif
    step(1'b1, 1'b1, AW'(OW - 1), 1'b1);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      if (o_out_valid) begin
        found = 1'b1;
        tests_run++;
        if (o_addr !== AW'(OW - 1)) begin
          tests_failed++;
          $display("FAIL zero_reg_addr: got %0d want %0d", o_addr, OW - 1);
        end
        tests_run++;
        if (o_onehot !== want_top) begin
          tests_failed++;
          $display("FAIL zero_reg_onehot: got %h want %h", o_onehot, want_top);
        end
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL zero_reg_timeout: out_valid got 0 want 1 within 8 cycles");
    end
  endtask

  task automatic test_random();
    logic rn, iv, ordy;
    for (int i = 0; i < 400; i++) begin
      rn   = ($urandom_range(0, 99) != 0);
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      step(rn, iv, AW'($urandom_range(0, OW - 1)), ordy);
      tests_run++;
      if (o_in_ready !== e_in_ready) begin
        tests_failed++;
        $display("FAIL rand_in_ready[%0d]: got %b want %b", i, o_in_ready, e_in_ready);
      end
      tests_run++;
      if (o_out_valid !== e_out_valid) begin
        tests_failed++;
        $display("FAIL rand_out_valid[%0d]: got %b want %b", i, o_out_valid, e_out_valid);
      end
      tests_run++;
      if (o_onehot !== e_onehot) begin
        tests_failed++;
        $display("FAIL rand_onehot[%0d]: got %h want %h", i, o_onehot, e_onehot);
      end
      if (e_out_valid) begin
        tests_run++;
        if (o_addr !== e_addr) begin
          tests_failed++;
          $display("FAIL rand_out_addr[%0d]: got %0d want %0d", i, o_addr, e_addr);
        end
      end
    end
    drain();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    out_ready = 1'b0;
    test_reset();
    test_latency();
    drain();
    test_backpressure();
    drain();
    test_simultaneous();
    test_reset_midflight();
    test_zero_reg();
    drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
